// File: rtl/instr_issue.sv
// Instruction issue sequencer: fetches a word, hands it to the ALU, writes the
// result back and resolves branch/halt from the ALU's post-condition opcode.
module instr_issue #(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   output logic [31:0]         alu_instruction,
   input  logic [3:0]          alu_modified_opcode,
   input  logic [31:0]         alu_result,
   output logic [3:0]          rf_raddr1,
   output logic [3:0]          rf_raddr2,
   output logic                rf_we,
   output logic [3:0]          rf_waddr,
   output logic [31:0]         rf_wdata,
   output logic [PC_WIDTH-1:0] pc,
   output logic                halted,
   output logic [31:0]         retired
);

   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_EXECUTE   = 3'd2;
   localparam logic [2:0] ST_WRITEBACK = 3'd3;
   localparam logic [2:0] ST_HALT      = 3'd4;

   localparam logic [3:0] OP_COMPARE = 4'hB;
   localparam logic [3:0] OP_WRITE_C = 4'hC;
   localparam logic [3:0] OP_BRANCH  = 4'hD;
   localparam logic [3:0] OP_HALT    = 4'hE;

   logic [2:0]          state;
   logic [31:0]         ir;
   logic [3:0]          mop;
   logic [3:0]          opcode;
   logic [3:0]          rd;
   logic [PC_WIDTH-1:0] branch_target;
   logic                writes_rd;
   logic                branch_taken;
   logic                halt_taken;

   assign opcode        = ir[27:24];
   assign rd            = ir[22:19];
   assign branch_target = PC_WIDTH'(ir[18:3]);
   assign writes_rd     = (opcode < OP_COMPARE) || (opcode == OP_WRITE_C);
   // mop equal to the opcode means the condition field let the op through
   assign branch_taken  = (opcode == OP_BRANCH) && (mop == OP_BRANCH);
   assign halt_taken    = (opcode == OP_HALT) && (mop == OP_HALT);

   assign imem_addr       = pc;
   assign alu_instruction = ir;
   assign rf_raddr1       = ir[18:15];
   assign rf_raddr2       = ir[14:11];
   assign halted          = (state == ST_HALT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_FETCH;
         pc       <= RESET_PC;
         ir       <= 32'hF000_0000;
         mop      <= 4'hF;
         imem_req <= 1'b0;
         rf_we    <= 1'b0;
         rf_waddr <= 4'd0;
         rf_wdata <= 32'd0;
         retired  <= 32'd0;
      end else begin
         rf_we <= 1'b0;
         case (state)
            ST_FETCH: begin
               if (imem_req && imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= ST_DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            ST_DECODE: begin
               state <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               // write strobe is registered here so it lands exactly on WRITEBACK
               mop <= alu_modified_opcode;
               if (writes_rd && (alu_modified_opcode == opcode)) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= rd;
                  rf_wdata <= alu_result;
               end
               state <= ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
               retired <= retired + 32'd1;
               if (halt_taken) begin
                  state <= ST_HALT;
               end else begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
                  pc       <= branch_taken ? branch_target : pc + PC_WIDTH'(1);
               end
            end
            ST_HALT: begin
               imem_req <= 1'b0;
            end
            default: begin
               state    <= ST_FETCH;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Sequencer on the instruction side of the ALU: fetches instruction words, drives the ALU instruction input and register-file read addresses, writes results back, and handles branch and halt.
- Sits between instruction memory, the register file and the ALU.
- Consumes the ALU's condition-resolved `modified_opcode` (4'hF = suppressed by the condition field) to decide branch taken and writeback enable.

Parameters:
- PC_WIDTH, 16, program counter and instruction address width (1..16)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request; held until acknowledged
- imem_addr  output  PC_WIDTH  fetch address, equals pc while imem_req=1
- imem_ack  input  1  fetch data valid this cycle
- imem_rdata  input  32  instruction word
- alu_instruction  output  32  instruction register to ALU
- alu_modified_opcode  input  4  ALU post-condition opcode
- alu_result  input  32  ALU result
- rf_raddr1  output  4  source 1 index = ir[18:15]
- rf_raddr2  output  4  source 2 index = ir[14:11]
- rf_we  output  1  register write strobe, one cycle
- rf_waddr  output  4  destination index = ir[22:19]
- rf_wdata  output  32  writeback data
- pc  output  PC_WIDTH  current program counter
- halted  output  1  high in HALT state
- retired  output  32  count of instructions completed (including suppressed ones), wraps

Behaviour:
- Instruction fields:
  - cond [31:28], opcode [27:24], s [23], rd [22:19], rs1 [18:15], rs2 [14:11], im_val [18:3].
- Reset values (asynchronous):
  - state=FETCH, pc=RESET_PC, ir=32'hF000_0000, imem_req=0, rf_we=0.
  - rf_waddr=0, rf_wdata=0, halted=0, retired=0.
- imem_req is registered. It rises the first clock after reset deasserts.
- States: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is terminal.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a clock with imem_ack=1: ir<=imem_rdata, imem_req<=0, go DECODE.
  - imem_ack outside FETCH is ignored.
- DECODE:
  - One cycle for register-file read.
  - rf_raddr1/2 are combinational from ir and valid in all states.
- EXECUTE:
  - alu_instruction=ir, which is always driven.
  - Capture res<=alu_result and mop<=alu_modified_opcode.
- WRITEBACK (single cycle):
  - Writing opcodes are 0..A and C. For these, if mop==opcode, then rf_we=1, rf_waddr=rd, rf_wdata=res. Otherwise rf_we=0.
  - B (compare), D, E and F never write.
  - Branch: if opcode==4'hD and mop==4'hD, pc<=im_val[PC_WIDTH-1:0]. Otherwise pc<=pc+1, wrapping modulo 2^PC_WIDTH.
  - Halt: if opcode==4'hE and mop==4'hE, go HALT (pc unchanged). Otherwise go FETCH.
  - retired increments by 1 here for every instruction, including halt.
  - A suppressed D or E behaves as NOP.
- rf_we is a registered pulse asserted only during the WRITEBACK cycle. It is 0 in all other states.
- HALT: halted=1, imem_req=0, no writes; remains until reset.
- Latency: 4 cycles per instruction with zero-wait ack. Each extra wait cycle before imem_ack adds 1.
- Reset during any state, including a pending fetch or WRITEBACK:
  - All outputs return to reset values immediately.
  - Any in-flight writeback is discarded.
  - Fetch restarts at RESET_PC.

Test Plan:
- Zero-wait fetch of 32'h0010_8000 (ADD rd=2, rs1=1, rs2=0), ALU result 5:
  - imem_req high 1 cycle after reset release.
  - rf_we pulses 3 cycles after ack with waddr=2, wdata=5.
  - pc=1, retired=1.
- Ack delayed 3 cycles:
  - imem_req and imem_addr held stable throughout the wait.
  - The instruction completes 3 cycles later than in the zero-wait case.
- Taken branch 32'h0D00_0050 (im_val=10), modified_opcode=D:
  - Next imem_addr=10, no rf_we.
- Same branch with modified_opcode=F:
  - Next imem_addr=pc+1.
- Conditionally suppressed ADD (modified_opcode=F):
  - rf_we stays 0, retired still increments.
- COMPARE (opcode B): no write.
- pc=16'hFFFF non-branch: next pc=0.
- Halt instruction 32'h0E00_0000:
  - halted=1, imem_req stays 0 for 20 cycles.
- Reset asserted mid-fetch:
  - imem_req drops the same cycle (asynchronous), pc=RESET_PC.
  - Refetch starts after release.
